alu_op_sequencer: RTL and testbench

Multi-cycle control sequencer that drives the 32-bit ALU from the other side of its op interface. It accepts one MIPS-subset instruction word per handshake, decodes it into the 3-bit ALU op and datapath strobes, and sequences EXEC/MEM/WB. It consumes the ALU zero flag to resolve `beq` and reports the next-PC selection. It sits between instruction fetch and the ALU/register-file/data-memory datapath.

---
 rtl/alu_seq_pkg.sv | 54 +++++
 rtl/alu_op_decode.sv | 42 ++++
 rtl/alu_op_sequencer.sv | 174 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, ALU op encodings, FSM state and decoded-control types for
// the ALU op sequencer.
package alu_seq_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_PCUPD, ST_ILLEGAL
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP
  } cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [2:0] alu_op;
    logic       alu_src_imm;
    logic       reg_dst_rd;
  } ctrl_t;

  // PC source for an instruction leaving EXEC straight into the PC update.
  function automatic logic [1:0] pc_sel_for(input cls_e cls, input logic take);
    logic [1:0] sel;
    case (cls)
      CLS_BRANCH: sel = take ? PC_BRANCH : PC_SEQ;
      CLS_JUMP:   sel = PC_JUMP;
      default:    sel = PC_SEQ;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decoder: opcode/funct to ALU op, operand select,
// destination select and instruction class, plus a legal bit.
import alu_seq_pkg::*;

module alu_op_decode (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       legal
);

  // Decode table; unknown encodings fall through as a NOP-class with legal low.
  always_comb begin
    ctrl  = '{cls: CLS_NOP, alu_op: ALU_AND, alu_src_imm: 1'b0, reg_dst_rd: 1'b0};
    legal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        ctrl.cls        = CLS_ALU;
        ctrl.reg_dst_rd = 1'b1;
        case (funct)
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          default: begin
            ctrl.cls        = CLS_NOP;
            ctrl.reg_dst_rd = 1'b0;
            legal           = 1'b0;
          end
        endcase
      end
      OP_ADDI: ctrl = '{cls: CLS_ALU,    alu_op: ALU_ADD, alu_src_imm: 1'b1, reg_dst_rd: 1'b0};
      OP_LW:   ctrl = '{cls: CLS_LOAD,   alu_op: ALU_ADD, alu_src_imm: 1'b1, reg_dst_rd: 1'b0};
      OP_SW:   ctrl = '{cls: CLS_STORE,  alu_op: ALU_ADD, alu_src_imm: 1'b1, reg_dst_rd: 1'b0};
      OP_BEQ:  ctrl = '{cls: CLS_BRANCH, alu_op: ALU_SUB, alu_src_imm: 1'b0, reg_dst_rd: 1'b0};
      OP_J:    ctrl = '{cls: CLS_JUMP,   alu_op: ALU_AND, alu_src_imm: 1'b0, reg_dst_rd: 1'b0};
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle MIPS-subset control sequencer (IDLE/DECODE/EXEC/MEM/WB/PCUPD).
// Define ALU_SEQ_ILLEGAL_TRAP_EN to trap unknown instructions in a sticky ILLEGAL state.
import alu_seq_pkg::*;

module alu_op_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ins_valid,
  input  logic [31:0] ins,
  output logic        ins_ready,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  input  logic        zero,
  output logic        mem_re,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        reg_we,
  output logic        reg_dst_rd,
  output logic        pc_upd,
  output logic [1:0]  pc_sel,
  output logic        illegal
);

  state_e      state_r;
  cls_e        cls_r;
  logic [5:0]  opcode_r;
  logic [5:0]  funct_r;
  logic        ins_ready_r;
  logic [2:0]  alu_op_r;
  logic        alu_src_imm_r;
  logic        mem_re_r;
  logic        mem_we_r;
  logic        reg_we_r;
  logic        reg_dst_rd_r;
  logic        pc_upd_r;
  logic [1:0]  pc_sel_r;
  ctrl_t       dec_ctrl_s;
  logic        dec_legal_s;
  logic        unused_ins_s;

  // Register fields (rs/rt/rd/immediate) are consumed by the datapath, not here.
  assign unused_ins_s = ^ins[25:6];

  alu_op_decode u_decode (
    .opcode (opcode_r),
    .funct  (funct_r),
    .ctrl   (dec_ctrl_s),
    .legal  (dec_legal_s)
  );

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic illegal_r;
  assign illegal = illegal_r;
`else
  assign illegal = 1'b0;
`endif

  // Sequencer FSM; every output is set on the edge entering the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      cls_r         <= CLS_NOP;
      opcode_r      <= 6'h00;
      funct_r       <= 6'h00;
      ins_ready_r   <= 1'b0;
      alu_op_r      <= 3'b000;
      alu_src_imm_r <= 1'b0;
      mem_re_r      <= 1'b0;
      mem_we_r      <= 1'b0;
      reg_we_r      <= 1'b0;
      reg_dst_rd_r  <= 1'b0;
      pc_upd_r      <= 1'b0;
      pc_sel_r      <= PC_SEQ;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      illegal_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ins_valid && ins_ready_r) begin
            opcode_r    <= ins[31:26];
            funct_r     <= ins[5:0];
            ins_ready_r <= 1'b0;
            state_r     <= ST_DECODE;
          end else begin
            ins_ready_r <= 1'b1;
          end
        end
        ST_DECODE: begin
          alu_op_r      <= dec_ctrl_s.alu_op;
          alu_src_imm_r <= dec_ctrl_s.alu_src_imm;
          reg_dst_rd_r  <= dec_ctrl_s.reg_dst_rd;
          cls_r         <= dec_legal_s ? dec_ctrl_s.cls : CLS_NOP;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
          if (!dec_legal_s) begin
            illegal_r <= 1'b1;
            state_r   <= ST_ILLEGAL;
          end else begin
            state_r   <= ST_EXEC;
          end
`else
          state_r       <= ST_EXEC;
`endif
        end
        ST_EXEC: begin
          case (cls_r)
            CLS_ALU: begin
              reg_we_r <= 1'b1;
              state_r  <= ST_WB;
            end
            CLS_LOAD: begin
              mem_re_r <= 1'b1;
              state_r  <= ST_MEM;
            end
            CLS_STORE: begin
              mem_we_r <= 1'b1;
              state_r  <= ST_MEM;
            end
            default: begin
              // beq resolves here: zero is sampled on this edge and held in pc_sel.
              pc_upd_r <= 1'b1;
              pc_sel_r <= pc_sel_for(cls_r, zero);
              state_r  <= ST_PCUPD;
            end
          endcase
        end
        ST_MEM: begin
          if (mem_ack) begin
            mem_re_r <= 1'b0;
            mem_we_r <= 1'b0;
            if (cls_r == CLS_LOAD) begin
              reg_we_r <= 1'b1;
              state_r  <= ST_WB;
            end else begin
              pc_upd_r <= 1'b1;
              pc_sel_r <= PC_SEQ;
              state_r  <= ST_PCUPD;
            end
          end
        end
        ST_WB: begin
          reg_we_r <= 1'b0;
          pc_upd_r <= 1'b1;
          pc_sel_r <= PC_SEQ;
          state_r  <= ST_PCUPD;
        end
        ST_PCUPD: begin
          pc_upd_r    <= 1'b0;
          pc_sel_r    <= PC_SEQ;
          ins_ready_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
        ST_ILLEGAL: begin
          ins_ready_r <= 1'b0;
          state_r     <= ST_ILLEGAL;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign ins_ready   = ins_ready_r;
  assign alu_op      = alu_op_r;
  assign alu_src_imm = alu_src_imm_r;
  assign mem_re      = mem_re_r;
  assign mem_we      = mem_we_r;
  assign reg_we      = reg_we_r;
  assign reg_dst_rd  = reg_dst_rd_r;
  assign pc_upd      = pc_upd_r;
  assign pc_sel      = pc_sel_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus random
// instructions checked against a cycle-latency reference model.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        ins_valid;
  logic [31:0] ins;
  logic        ins_ready;
  logic [2:0]  alu_op;
  logic        alu_src_imm;
  logic        zero;
  logic        mem_re;
  logic        mem_we;
  logic        mem_ack;
  logic        reg_we;
  logic        reg_dst_rd;
  logic        pc_upd;
  logic [1:0]  pc_sel;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  // Observations of one instruction, cycle numbers relative to the accept cycle T.
  int         obs_pc_cyc, obs_pc_cnt, obs_we_cyc, obs_we_cnt, obs_re_cnt, obs_wr_cnt, obs_busy_ready;
  logic [1:0] obs_pc_sel;
  logic [2:0] obs_op2, obs_op_pc;
  logic       obs_imm2, obs_dst, obs_ready_after, obs_illegal_any, obs_accept_ok;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins(ins), .ins_ready(ins_ready),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .zero(zero), .mem_re(mem_re),
    .mem_we(mem_we), .mem_ack(mem_ack), .reg_we(reg_we), .reg_dst_rd(reg_dst_rd),
    .pc_upd(pc_upd), .pc_sel(pc_sel), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected behaviour of one instruction, from the decode table and latency rules.
  task automatic ref_expect(input logic [31:0] w, input logic z, input int n,
                            output int e_pc, output logic [1:0] e_sel, output int e_we,
                            output logic e_dst, output int e_re, output int e_wr,
                            output logic [2:0] e_op, output logic e_imm, output bit e_known);
    logic [5:0] op, fn;
    op = w[31:26]; fn = w[5:0];
    e_known = 1'b1; e_pc = 3; e_sel = 2'b00; e_we = -1; e_dst = 1'b0;
    e_re = 0; e_wr = 0; e_op = 3'b000; e_imm = 1'b0;
    if (op == 6'h00 && (fn == 6'h24 || fn == 6'h25 || fn == 6'h20 || fn == 6'h22 || fn == 6'h2A)) begin
      case (fn)
        6'h24: e_op = 3'b000;
        6'h25: e_op = 3'b001;
        6'h20: e_op = 3'b010;
        6'h22: e_op = 3'b110;
        default: e_op = 3'b111;
      endcase
      e_we = 3; e_dst = 1'b1; e_pc = 4;
    end else if (op == 6'h08) begin
      e_op = 3'b010; e_imm = 1'b1; e_we = 3; e_pc = 4;
    end else if (op == 6'h23) begin
      e_op = 3'b010; e_imm = 1'b1; e_re = n; e_we = 3 + n; e_pc = 4 + n;
    end else if (op == 6'h2B) begin
      e_op = 3'b010; e_imm = 1'b1; e_wr = n; e_pc = 3 + n;
    end else if (op == 6'h04) begin
      e_op = 3'b110; e_sel = z ? 2'b01 : 2'b00;
    end else if (op == 6'h02) begin
      e_sel = 2'b10;
    end else begin
      e_known = 1'b0;
    end
  endtask

  // Drives one instruction through the handshake and records what the DUT does.
  task automatic run_instr(input logic [31:0] w, input logic z, input int n_ack, input bit busy_valid);
    int guard, memc;
    bit done;
    obs_pc_cyc = -1; obs_pc_cnt = 0; obs_we_cyc = -1; obs_we_cnt = 0; obs_re_cnt = 0;
    obs_wr_cnt = 0; obs_busy_ready = 0; obs_pc_sel = 2'b11; obs_op2 = 3'bxxx; obs_op_pc = 3'bxxx;
    obs_imm2 = 1'bx; obs_dst = 1'bx; obs_ready_after = 1'b0; obs_illegal_any = 1'b0;
    guard = 0; memc = 0; done = 1'b0;
    while (ins_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    obs_accept_ok = (ins_ready === 1'b1);
    ins = w; ins_valid = 1'b1;
    @(posedge clk);
    #1;
    ins_valid = busy_valid;
    ins = 32'h0800_0000;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      if (obs_pc_cyc >= 0 && k == obs_pc_cyc + 1) begin
        obs_ready_after = ins_ready;
        ins_valid = 1'b0;
        done = 1'b1;
      end else begin
        if (k == 2) begin obs_op2 = alu_op; obs_imm2 = alu_src_imm; end
        if (ins_ready) obs_busy_ready++;
        if (illegal) obs_illegal_any = 1'b1;
        if (pc_upd) begin
          if (obs_pc_cnt == 0) begin obs_pc_cyc = k; obs_pc_sel = pc_sel; obs_op_pc = alu_op; end
          obs_pc_cnt++;
        end
        if (reg_we) begin
          if (obs_we_cnt == 0) begin obs_we_cyc = k; obs_dst = reg_dst_rd; end
          obs_we_cnt++;
        end
        if (mem_re) obs_re_cnt++;
        if (mem_we) obs_wr_cnt++;
        zero = (k == 2) ? z : ~z;
        mem_ack = (k == 1);
        if (mem_re || mem_we) begin
          memc++;
          mem_ack = (memc >= n_ack);
        end
      end
    end
    ins_valid = 1'b0; mem_ack = 1'b0; zero = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    ins_valid = 1'b0; ins = 32'h0; zero = 1'b0; mem_ack = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ins_ready, alu_op, alu_src_imm, mem_re, mem_we, reg_we, reg_dst_rd, pc_upd, pc_sel, illegal} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {ins_ready, alu_op, alu_src_imm, mem_re, mem_we, reg_we, reg_dst_rd, pc_upd, pc_sel, illegal});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ins_ready !== 1'b0) begin errors++; $display("FAIL reset_release_ready: got %b expected 0", ins_ready); end
    @(negedge clk);
    checks++;
    if (ins_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", ins_ready); end
  endtask

  task automatic test_rtype_sub();
    run_instr(32'h0123_4822, 1'b0, 1, 1'b0);
    checks++;
    if (obs_op2 !== 3'b110) begin errors++; $display("FAIL sub_alu_op: got %b expected 110", obs_op2); end
    checks++;
    if (obs_we_cyc != 3 || obs_we_cnt != 1 || obs_dst !== 1'b1) begin
      errors++; $display("FAIL sub_reg_we: cycle %0d count %0d dst %b expected cycle 3 count 1 dst 1", obs_we_cyc, obs_we_cnt, obs_dst);
    end
    checks++;
    if (obs_pc_cyc != 4 || obs_pc_sel !== 2'b00 || obs_pc_cnt != 1) begin
      errors++; $display("FAIL sub_pc_upd: cycle %0d sel %b count %0d expected cycle 4 sel 00 count 1", obs_pc_cyc, obs_pc_sel, obs_pc_cnt);
    end
  endtask

  task automatic test_beq();
    for (int t = 0; t < 2; t++) begin
      logic z;
      z = (t == 0);
      run_instr(32'h1085_0010, z, 1, 1'b0);
      checks++;
      if (obs_pc_cyc != 3 || obs_pc_sel !== (z ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL beq_pc zero=%b: cycle %0d sel %b expected cycle 3 sel %b", z, obs_pc_cyc, obs_pc_sel, z ? 2'b01 : 2'b00);
      end
      checks++;
      if (obs_we_cnt != 0 || obs_op2 !== 3'b110) begin
        errors++; $display("FAIL beq_ctrl zero=%b: reg_we count %0d alu_op %b expected 0 and 110", z, obs_we_cnt, obs_op2);
      end
    end
  endtask

  task automatic test_mem();
    run_instr(32'h8C22_0004, 1'b0, 3, 1'b0);
    checks++;
    if (obs_re_cnt != 3 || obs_wr_cnt != 0) begin
      errors++; $display("FAIL lw_mem_re: re %0d we %0d expected 3 and 0", obs_re_cnt, obs_wr_cnt);
    end
    checks++;
    if (obs_we_cyc != 6 || obs_we_cnt != 1 || obs_pc_cyc != 7) begin
      errors++; $display("FAIL lw_wb_pc: reg_we cycle %0d count %0d pc cycle %0d expected 6 1 7", obs_we_cyc, obs_we_cnt, obs_pc_cyc);
    end
    run_instr(32'hAC22_0008, 1'b0, 1, 1'b0);
    checks++;
    if (obs_wr_cnt != 1 || obs_re_cnt != 0 || obs_we_cnt != 0 || obs_pc_cyc != 4 || obs_pc_sel !== 2'b00) begin
      errors++; $display("FAIL sw_ack_first: mem_we %0d mem_re %0d reg_we %0d pc cycle %0d sel %b expected 1 0 0 4 00",
                         obs_wr_cnt, obs_re_cnt, obs_we_cnt, obs_pc_cyc, obs_pc_sel);
    end
  endtask

  task automatic test_back_to_back();
    run_instr(32'h2001_0005, 1'b0, 1, 1'b1);
    checks++;
    if (obs_busy_ready != 0 || obs_pc_sel !== 2'b00 || obs_pc_cyc != 4 || obs_imm2 !== 1'b1) begin
      errors++; $display("FAIL busy_ignored: ready_while_busy %0d sel %b pc cycle %0d imm %b expected 0 00 4 1",
                         obs_busy_ready, obs_pc_sel, obs_pc_cyc, obs_imm2);
    end
    checks++;
    if (obs_ready_after !== 1'b1) begin errors++; $display("FAIL ready_after_pc_upd: got %b expected 1", obs_ready_after); end
    run_instr(32'h0800_0040, 1'b0, 1, 1'b0);
    checks++;
    if (obs_pc_cyc != 3 || obs_pc_sel !== 2'b10 || obs_op_pc !== 3'b000) begin
      errors++; $display("FAIL jump_next: pc cycle %0d sel %b alu_op %b expected 3 10 000", obs_pc_cyc, obs_pc_sel, obs_op_pc);
    end
  endtask

  task automatic test_reset_mid_mem();
    int guard, bad;
    guard = 0; bad = 0;
    while (ins_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    ins = 32'h8C22_0000; ins_valid = 1'b1; mem_ack = 1'b0;
    @(posedge clk);
    #1 ins_valid = 1'b0;
    guard = 0;
    do begin @(negedge clk); guard++; end while (mem_re !== 1'b1 && guard < 10);
    checks++;
    if (mem_re !== 1'b1) begin errors++; $display("FAIL lw_reach_mem: mem_re %b expected 1", mem_re); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ins_ready, alu_op, mem_re, mem_we, reg_we, pc_upd, pc_sel} !== 10'h0) begin
      errors++; $display("FAIL async_abort: got %b expected all zero", {ins_ready, alu_op, mem_re, mem_we, reg_we, pc_upd, pc_sel});
    end
    mem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (reg_we || pc_upd) bad++;
    end
    mem_ack = 1'b0;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (reg_we || pc_upd) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL no_partial_strobe: %0d strobe cycles expected 0", bad); end
    run_instr(32'h0043_202A, 1'b0, 1, 1'b0);
    checks++;
    if (obs_op2 !== 3'b111 || obs_we_cyc != 3 || obs_pc_cyc != 4) begin
      errors++; $display("FAIL slt_after_reset: alu_op %b reg_we cycle %0d pc cycle %0d expected 111 3 4", obs_op2, obs_we_cyc, obs_pc_cyc);
    end
  endtask

  task automatic test_illegal();
    run_instr(32'hFC00_0000, 1'b0, 1, 1'b0);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    checks++;
    if (obs_illegal_any !== 1'b1 || obs_pc_cnt != 0 || obs_busy_ready != 0 || illegal !== 1'b1) begin
      errors++; $display("FAIL illegal_trap: illegal %b pc_upd %0d ready %0d expected 1 0 0", illegal, obs_pc_cnt, obs_busy_ready);
    end
    do_reset();
`else
    checks++;
    if (obs_pc_cyc != 3 || obs_pc_sel !== 2'b00 || obs_illegal_any !== 1'b0 || obs_we_cnt != 0) begin
      errors++; $display("FAIL illegal_nop: pc cycle %0d sel %b illegal %b reg_we %0d expected 3 00 0 0",
                         obs_pc_cyc, obs_pc_sel, obs_illegal_any, obs_we_cnt);
    end
`endif
  endtask

  task automatic test_random();
    logic [5:0] ops [7];
    logic [5:0] fns [6];
    logic [31:0] w;
    logic z, e_dst, e_imm;
    logic [1:0] e_sel;
    logic [2:0] e_op;
    int n, e_pc, e_we, e_re, e_wr, hi;
    bit e_known;
    ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
    fns = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h01};
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    hi = 5;
`else
    hi = 6;
`endif
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      w[31:26] = ops[$urandom_range(0, hi)];
      w[5:0] = fns[$urandom_range(0, hi - 1)];
      z = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 4);
      ref_expect(w, z, n, e_pc, e_sel, e_we, e_dst, e_re, e_wr, e_op, e_imm, e_known);
      run_instr(w, z, n, 1'($urandom_range(0, 1)));
      checks++;
      if (!obs_accept_ok || obs_pc_cyc != e_pc || obs_pc_sel !== e_sel || obs_pc_cnt != 1) begin
        errors++; $display("FAIL rand_pc ins=%h: cycle %0d sel %b count %0d expected %0d %b 1", w, obs_pc_cyc, obs_pc_sel, obs_pc_cnt, e_pc, e_sel);
      end
      checks++;
      if (obs_we_cyc != e_we || obs_we_cnt != (e_we >= 0 ? 1 : 0) || (e_we >= 0 && obs_dst !== e_dst)) begin
        errors++; $display("FAIL rand_reg_we ins=%h: cycle %0d count %0d dst %b expected %0d dst %b", w, obs_we_cyc, obs_we_cnt, obs_dst, e_we, e_dst);
      end
      checks++;
      if (obs_re_cnt != e_re || obs_wr_cnt != e_wr) begin
        errors++; $display("FAIL rand_mem ins=%h: re %0d we %0d expected %0d %0d", w, obs_re_cnt, obs_wr_cnt, e_re, e_wr);
      end
      if (e_known) begin
        checks++;
        if (obs_op2 !== e_op || obs_imm2 !== e_imm || obs_op_pc !== e_op) begin
          errors++; $display("FAIL rand_alu ins=%h: op %b imm %b op_at_pc %b expected %b %b", w, obs_op2, obs_imm2, obs_op_pc, e_op, e_imm);
        end
      end
      checks++;
      if (obs_busy_ready != 0 || obs_ready_after !== 1'b1 || obs_illegal_any !== 1'b0) begin
        errors++; $display("FAIL rand_ready ins=%h: busy_ready %0d ready_after %b illegal %b expected 0 1 0",
                           w, obs_busy_ready, obs_ready_after, obs_illegal_any);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype_sub();
    test_beq();
    test_mem();
    test_back_to_back();
    test_reset_mid_mem();
    test_illegal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
